// File: rtl/wdt_pkg.sv
// Shared types and default constants for the watchdog kicker.
package wdt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HOLDOFF = 3'd1,
        ST_RUN     = 3'd2,
        ST_STARVED = 3'd3,
        ST_TRIPPED = 3'd4
    } wdt_state_e;

    localparam int WDT_KICK_PERIOD  = 100;
    localparam int WDT_ALIVE_WINDOW = 400;
    localparam int WDT_HOLDOFF      = 16;
    localparam int WDT_CNT_W        = 9;

    // Wait time of the watchdog being serviced; kicks must come faster than this.
    localparam int WDT_WAIT_TIME    = 500;

    function automatic int wdt_max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/wdt_cycle_counter.sv
// Up-counter with synchronous clear that saturates at a terminal value and flags it.
module wdt_cycle_counter
    import wdt_pkg::*;
#(
    parameter int CNT_W = WDT_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             inc_i,
    input  logic [CNT_W-1:0] term_i,
    output logic             term_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear wins over increment; the count never moves past the terminal value.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != term_i)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign term_o = (cnt_q == term_i);

endmodule

// File: rtl/wdt_kicker.sv
// Watchdog servicing block: periodic kick while alive strobes keep arriving,
// backs off when starved and restarts after the watchdog's own reset clears.
module wdt_kicker
    import wdt_pkg::*;
#(
    parameter int KICK_PERIOD  = WDT_KICK_PERIOD,
    parameter int ALIVE_WINDOW = WDT_ALIVE_WINDOW,
    parameter int HOLDOFF      = WDT_HOLDOFF,
    parameter int CNT_W        = WDT_CNT_W
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       alive,
    input  logic       wdt_rst,
    output logic       kick,
    output logic       starved,
    output logic       tripped,
    output logic [7:0] kick_cnt
);

    // A kick period at or above the watchdog wait time would let it fire while healthy.
    if (KICK_PERIOD >= WDT_WAIT_TIME) begin : g_bad_kick_period
        $error("wdt_kicker: KICK_PERIOD must be below the watchdog wait time");
    end
    if ((1 << CNT_W) <= wdt_max3(KICK_PERIOD, ALIVE_WINDOW, HOLDOFF)) begin : g_bad_cnt_w
        $error("wdt_kicker: CNT_W too narrow for the configured periods");
    end

    localparam logic [CNT_W-1:0] HOLD_TERM  = CNT_W'(HOLDOFF - 1);
    localparam logic [CNT_W-1:0] PER_TERM   = CNT_W'(KICK_PERIOD - 1);
    localparam logic [CNT_W-1:0] ALIVE_TERM = CNT_W'(ALIVE_WINDOW - 1);

    wdt_state_e state_q;
    wdt_state_e state_d;
    logic       kick_q;
    logic       kick_d;
    logic       starved_q;
    logic       tripped_q;
    logic [7:0] kick_cnt_q;

    logic hold_clr, hold_inc, hold_term;
    logic per_clr, per_inc, per_term;
    logic alive_clr, alive_inc, alive_term;

    wdt_cycle_counter #(.CNT_W(CNT_W)) u_hold_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (hold_clr),
        .inc_i  (hold_inc),
        .term_i (HOLD_TERM),
        .term_o (hold_term)
    );

    wdt_cycle_counter #(.CNT_W(CNT_W)) u_per_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (per_clr),
        .inc_i  (per_inc),
        .term_i (PER_TERM),
        .term_o (per_term)
    );

    wdt_cycle_counter #(.CNT_W(CNT_W)) u_alive_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (alive_clr),
        .inc_i  (alive_inc),
        .term_i (ALIVE_TERM),
        .term_o (alive_term)
    );

    // Next state and counter controls; disable beats watchdog reset beats local moves.
    always_comb begin
        state_d   = state_q;
        kick_d    = 1'b0;
        hold_clr  = 1'b1;
        hold_inc  = 1'b0;
        per_clr   = 1'b1;
        per_inc   = 1'b0;
        alive_clr = 1'b1;
        alive_inc = 1'b0;
        if (!en) begin
            state_d = ST_IDLE;
        end else if (wdt_rst && (state_q != ST_IDLE)) begin
            state_d = ST_TRIPPED;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_HOLDOFF;
                end
                ST_HOLDOFF: begin
                    hold_clr = hold_term;
                    hold_inc = 1'b1;
                    if (hold_term) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    per_clr   = per_term;
                    per_inc   = 1'b1;
                    alive_clr = alive;
                    alive_inc = 1'b1;
                    if (!alive && alive_term) begin
                        state_d = ST_STARVED;
                    end else begin
                        kick_d = per_term;
                    end
                end
                ST_STARVED: begin
                    per_clr   = 1'b0;
                    alive_clr = 1'b0;
                    if (alive) begin
                        state_d   = ST_RUN;
                        per_clr   = 1'b1;
                        alive_clr = 1'b1;
                    end
                end
                ST_TRIPPED: begin
                    state_d = ST_HOLDOFF;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and registered outputs; the kick count survives disable but not reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            kick_q     <= 1'b0;
            starved_q  <= 1'b0;
            tripped_q  <= 1'b0;
            kick_cnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            kick_q    <= kick_d;
            starved_q <= (state_d == ST_STARVED);
            tripped_q <= (state_d == ST_TRIPPED);
            if (kick_q && (kick_cnt_q != 8'hFF)) begin
                kick_cnt_q <= kick_cnt_q + 8'd1;
            end
        end
    end

    assign kick     = kick_q;
    assign starved  = starved_q;
    assign tripped  = tripped_q;
    assign kick_cnt = kick_cnt_q;

endmodule

// File: tb/tb_wdt_kicker.sv
// Directed bench for wdt_kicker with KICK_PERIOD=8, ALIVE_WINDOW=20, HOLDOFF=4.
// Cycle numbers below are posedge counts; an input changed just after edge N-1
// is sampled at edge N, and outputs are read 1 time unit after an edge.
module tb_wdt_kicker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       alive;
    logic       wdt_rst;
    logic       kick;
    logic       starved;
    logic       tripped;
    logic [7:0] kick_cnt;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Edge counter used to place stimulus and checks.
    always @(posedge clk) cyc <= cyc + 1;

    wdt_kicker #(
        .KICK_PERIOD  (8),
        .ALIVE_WINDOW (20),
        .HOLDOFF      (4),
        .CNT_W        (9)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .alive    (alive),
        .wdt_rst  (wdt_rst),
        .kick     (kick),
        .starved  (starved),
        .tripped  (tripped),
        .kick_cnt (kick_cnt)
    );

    task automatic runTo(input int e);
        while (cyc < e) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic enV, input logic aliveV, input logic wdtV);
        en      = enV;
        alive   = aliveV;
        wdt_rst = wdtV;
    endtask

    task automatic aliveAt(input int e);
        runTo(e - 1);
        alive = 1'b1;
        runTo(e);
        alive = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Linear directed scenario.
    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);

        runTo(1);
        checkOutput("reset_kick", kick, 8'd0);
        checkOutput("reset_starved", starved, 8'd0);
        checkOutput("reset_tripped", tripped, 8'd0);
        checkOutput("reset_kick_cnt", kick_cnt, 8'd0);
        runTo(2);
        rst_n = 1'b1;

        // Startup: en sampled at edge 5, RUN after 9, first kick at 5+4+8=17.
        runTo(4);
        applyStimulus(1'b1, 1'b0, 1'b0);
        aliveAt(15);
        runTo(16);
        checkOutput("startup_no_early_kick", kick, 8'd0);
        runTo(17);
        checkOutput("startup_first_kick", kick, 8'd1);
        runTo(18);
        checkOutput("startup_kick_width", kick, 8'd0);
        aliveAt(25);
        checkOutput("startup_kick2", kick, 8'd1);
        runTo(33);
        checkOutput("startup_kick3", kick, 8'd1);
        aliveAt(35);
        runTo(41);
        checkOutput("startup_kick4", kick, 8'd1);
        checkOutput("startup_cnt_before", kick_cnt, 8'd3);
        runTo(42);
        checkOutput("startup_cnt_after", kick_cnt, 8'd4);

        // Starvation: last alive at 45, window expires at 65, which is also a kick edge.
        aliveAt(45);
        runTo(57);
        checkOutput("starve_last_kick", kick, 8'd1);
        runTo(64);
        checkOutput("starve_not_yet", starved, 8'd0);
        runTo(65);
        checkOutput("starve_entered", starved, 8'd1);
        checkOutput("collision_kick_suppressed", kick, 8'd0);
        runTo(66);
        checkOutput("starve_cnt", kick_cnt, 8'd6);
        runTo(73);
        checkOutput("starve_no_kick", kick, 8'd0);
        checkOutput("starve_held", starved, 8'd1);

        // Recovery: alive at 80 returns to RUN, next kick at 88.
        runTo(79);
        checkOutput("starve_before_alive", starved, 8'd1);
        alive = 1'b1;
        runTo(80);
        alive = 1'b0;
        checkOutput("recover_starved_clear", starved, 8'd0);
        aliveAt(84);
        runTo(87);
        checkOutput("recover_no_early_kick", kick, 8'd0);
        runTo(88);
        checkOutput("recover_kick", kick, 8'd1);

        // Alive arrives exactly in the expiry cycle (104), which is also a kick edge.
        aliveAt(104);
        checkOutput("alive_wins_kick", kick, 8'd1);
        checkOutput("alive_wins_run", starved, 8'd0);
        runTo(105);
        checkOutput("alive_wins_cnt", kick_cnt, 8'd9);

        // Watchdog trip: wdt_rst sampled high on edges 110..115.
        runTo(109);
        checkOutput("trip_before", tripped, 8'd0);
        wdt_rst = 1'b1;
        runTo(110);
        checkOutput("trip_entered", tripped, 8'd1);
        runTo(112);
        checkOutput("trip_no_kick", kick, 8'd0);
        checkOutput("trip_held", tripped, 8'd1);
        runTo(115);
        checkOutput("trip_last", tripped, 8'd1);
        wdt_rst = 1'b0;
        runTo(116);
        checkOutput("trip_released", tripped, 8'd0);
        runTo(127);
        checkOutput("trip_restart_no_early", kick, 8'd0);
        runTo(128);
        checkOutput("trip_restart_kick", kick, 8'd1);
        runTo(129);
        checkOutput("trip_restart_cnt", kick_cnt, 8'd10);

        // Starve again (alive at 130, expiry 150), then disable while STARVED.
        aliveAt(130);
        runTo(144);
        checkOutput("run_kick_144", kick, 8'd1);
        runTo(150);
        checkOutput("starve2_entered", starved, 8'd1);
        runTo(152);
        checkOutput("starve2_no_kick", kick, 8'd0);
        runTo(155);
        en = 1'b0;
        runTo(156);
        checkOutput("disable_starved_clear", starved, 8'd0);
        checkOutput("disable_cnt_kept", kick_cnt, 8'd12);

        // Re-enable at 161, kicks at 173 and 181, then async reset mid-RUN.
        runTo(160);
        en = 1'b1;
        runTo(173);
        checkOutput("reenable_kick", kick, 8'd1);
        runTo(174);
        checkOutput("reenable_cnt", kick_cnt, 8'd13);
        runTo(181);
        checkOutput("pre_reset_kick", kick, 8'd1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_kick", kick, 8'd0);
        checkOutput("async_reset_cnt", kick_cnt, 8'd0);
        checkOutput("async_reset_starved", starved, 8'd0);
        checkOutput("async_reset_tripped", tripped, 8'd0);

        // Saturation: restart at 185, kicks at 197 + 8k, alive every 10 cycles.
        runTo(184);
        rst_n = 1'b1;
        for (int e = 190; e <= 2220; e += 10) begin
            aliveAt(e);
        end
        runTo(2229);
        checkOutput("sat_kick_255th", kick, 8'd1);
        checkOutput("sat_cnt_254", kick_cnt, 8'd254);
        for (int e = 2230; e <= 2590; e += 10) begin
            aliveAt(e);
        end
        runTo(2597);
        checkOutput("sat_kick_continues", kick, 8'd1);
        runTo(2598);
        checkOutput("sat_cnt_held", kick_cnt, 8'd255);
        checkOutput("sat_kick_width", kick, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wdt_kicker.md
Name: wdt_kicker

Overview:
- Servicing side of the watchdog interface. Generates the periodic one-cycle kick pulse that the watchdog timer consumes on its enable input.
- Kicks only while the monitored logic proves liveness by strobing `alive` often enough. If `alive` stops, kicks are withheld and the watchdog is allowed to fire.
- Observes the watchdog's reset output, holds off kicking while it is asserted, then restarts cleanly.

Parameters:
- KICK_PERIOD, 100, cycles between kick pulses in RUN. Integration rule: must be less than the watchdog wait time (500).
- ALIVE_WINDOW, 400, max cycles allowed between `alive` strobes before kicks are withheld.
- HOLDOFF, 16, settling cycles after enable or after watchdog reset release, before RUN.
- CNT_W, 9, counter width. Must satisfy 2^CNT_W > max(KICK_PERIOD, ALIVE_WINDOW, HOLDOFF).

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- en  input  1  block enable, level sensitive
- alive  input  1  liveness strobe from monitored logic, one or more cycles
- wdt_rst  input  1  reset output of the watchdog, level, active-high
- kick  output  1  one-cycle service pulse to the watchdog enable
- starved  output  1  high while kicks are withheld for lack of `alive`
- tripped  output  1  high while `wdt_rst` is observed asserted
- kick_cnt  output  8  number of kicks issued, saturating at 255

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous and active-low. All outputs are registered.
- Reset (`rst_n`=0, any time, including mid-operation):
  - state=IDLE; kick=0, starved=0, tripped=0, kick_cnt=0.
  - All internal counters cleared.
- States: IDLE, HOLDOFF, RUN, STARVED, TRIPPED. Transition priority: en=0 > wdt_rst=1 > local transitions.
- Any state, en=0: next state IDLE, counters cleared, kick=0. kick_cnt is retained.
- Any non-IDLE state, wdt_rst=1: next state TRIPPED.
- IDLE: en=1 → HOLDOFF; hold_cnt=0.
- HOLDOFF:
  - hold_cnt increments each cycle.
  - When hold_cnt==HOLDOFF-1 → RUN, with per_cnt=0 and alive_cnt=0.
  - HOLDOFF therefore lasts exactly HOLDOFF cycles.
- RUN, period counter:
  - per_cnt increments each cycle.
  - When per_cnt==KICK_PERIOD-1: per_cnt wraps to 0 and kick=1 for the following cycle.
  - kick is 0 in all other cycles.
- RUN, alive window:
  - alive=1: alive_cnt cleared.
  - Otherwise alive_cnt increments.
  - When alive_cnt==ALIVE_WINDOW-1 and alive=0 → STARVED.
- RUN, simultaneous events:
  - alive=1 in the expiry cycle: alive wins, stay in RUN.
  - Kick due in the same cycle as expiry: the kick is suppressed.
- STARVED:
  - starved=1, kick held 0, per_cnt frozen.
  - alive=1 → RUN, with per_cnt=0, alive_cnt=0, starved=0 on the next cycle.
- TRIPPED:
  - tripped=1, kick held 0.
  - Stays while wdt_rst=1.
  - wdt_rst=0 → HOLDOFF, hold_cnt=0, tripped=0.
- kick_cnt:
  - Increments on every cycle kick=1; holds at 255.
  - Cleared only by rst_n.
- Latency:
  - First kick is asserted exactly HOLDOFF+KICK_PERIOD cycles after en is first sampled high.
  - Thereafter kicks repeat every KICK_PERIOD cycles, each 1 cycle wide.
- Counters never exceed their terminal value; there is no wrap-around other than the per_cnt reload.

Decomposition:
- Package wdt_pkg holds:
  - state enum (IDLE, HOLDOFF, RUN, STARVED, TRIPPED) and its encoding;
  - default constants WDT_KICK_PERIOD, WDT_ALIVE_WINDOW, WDT_HOLDOFF;
  - WDT_WAIT_TIME=500, for the integration assertion.
- One natural sub-module: wdt_cycle_counter, a CNT_W-bit counter with clear, enable, terminal-value compare and terminal flag.
  - Instantiated three times: hold_cnt, per_cnt, alive_cnt.
  - FSM and output registers stay in wdt_kicker.

Test Plan:
Common settings: KICK_PERIOD=8, ALIVE_WINDOW=20, HOLDOFF=4, `alive` pulsed every 10 cycles unless stated.
- Startup: rst_n released, en=1 at cycle 0 → kick first high at cycle 12, then 20, 28, 36; each pulse 1 cycle; kick_cnt=4 at cycle 37.
- Starvation: alive stopped after its last pulse at cycle 30 → STARVED at cycle 50; starved=1; no kick after cycle 44. Alive pulse at cycle 60 → starved=0 at 61, next kick at 69.
- Edge collision: alive_cnt expiry and per_cnt==7 in the same cycle → no kick, STARVED entered. Alive pulse in that expiry cycle → stays RUN, kick issued.
- Watchdog trip: wdt_rst high cycles 40–45 → tripped=1 cycles 41–46, kick=0. wdt_rst falls → HOLDOFF 4 cycles, then kick at HOLDOFF exit + 8.
- Reset/disable mid-operation: rst_n low during RUN → all outputs 0 immediately (asynchronous), kick_cnt=0. en low during STARVED → IDLE, starved=0, kick_cnt retained.
- Saturation: run 300 kick periods → kick_cnt holds 255, kick pulses continue.
